ripple_count_capture: RTL

- Sits directly downstream of the 4-bit JK ripple counter.
- Resynchronises the counter's asynchronous, skewed output bits into the `clk` domain and rejects ripple glitches with a stability filter.
- Publishes each settled count through a valid/ready handshake, with wrap detection and an epoch counter.
- Lets downstream synchronous logic consume the ripple count safely.

---
 rtl/ripple_count_capture.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ripple_count_capture.sv
// ripple_count_capture: resynchronises a 4-bit ripple counter into the clk domain,
// filters ripple glitches, and publishes each settled count over valid/ready with wrap
// and epoch tracking.
// Optional feature macro: RIPPLE_CAPTURE_STEP_CHECK_EN builds the +1 step comparator
// behind step_err; without it step_err is tied low.
module ripple_count_capture #(
   parameter int unsigned WIDTH         = 4,
   parameter int unsigned STABLE_CYCLES = 2,
   parameter int unsigned EPOCH_W       = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   cnt_in,
   output logic [WIDTH-1:0]   cnt_out,
   output logic               cnt_valid,
   input  logic               cnt_ready,
   output logic               wrap_pulse,
   output logic [EPOCH_W-1:0] epoch,
   output logic               step_err,
   output logic               overrun
);

   localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {StInit, StTrack, StSettle} state_e;

   state_e           state;
   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] last;
   logic [WIDTH-1:0] cand;
   logic [3:0]       stab;
   // The synchroniser leaves reset holding zeros that were never sampled from cnt_in;
   // INIT ignores the first two edges so the baseline is a real sample.
   logic [1:0]       flush;

   logic match_cand;
   logic match_last;
   logic stab_done;
   logic is_wrap;

   // Two-flop resynchroniser on all counter bits; only sync2 feeds logic
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= cnt_in;
         sync2 <= sync1;
      end
   end

   // Comparisons shared by the FSM
   always_comb begin
      match_cand = (sync2 == cand);
      match_last = (sync2 == last);
      stab_done  = (stab == STAB_MAX);
      is_wrap    = (last == '1) && (cand == '0);
   end

   // Stability filter FSM with registered outputs and handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= StInit;
         last       <= '0;
         cand       <= '0;
         stab       <= '0;
         flush      <= '0;
         cnt_out    <= '0;
         cnt_valid  <= 1'b0;
         wrap_pulse <= 1'b0;
         epoch      <= '0;
         overrun    <= 1'b0;
`ifdef RIPPLE_CAPTURE_STEP_CHECK_EN
         step_err   <= 1'b0;
`endif
      end else begin
         wrap_pulse <= 1'b0;
`ifdef RIPPLE_CAPTURE_STEP_CHECK_EN
         step_err   <= 1'b0;
`endif
         // Consumption; overridden below if an accept lands on the same edge
         if (cnt_valid && cnt_ready) begin
            cnt_valid <= 1'b0;
         end

         unique case (state)
            StInit: begin
               if (flush != 2'd2) begin
                  flush <= flush + 2'd1;
               end else begin
                  cand <= sync2;
                  if (match_cand) begin
                     if (stab_done) begin
                        // Baseline: silent, no handshake or events
                        last    <= cand;
                        cnt_out <= cand;
                        state   <= StTrack;
                     end else begin
                        stab <= stab + 4'd1;
                     end
                  end else begin
                     stab <= 4'd1;
                  end
               end
            end

            StTrack: begin
               if (!match_last) begin
                  cand  <= sync2;
                  stab  <= 4'd1;
                  state <= StSettle;
               end
            end

            StSettle: begin
               if (match_cand) begin
                  if (stab_done) begin
                     last      <= cand;
                     cnt_out   <= cand;
                     cnt_valid <= 1'b1;
                     state     <= StTrack;
                     if (cnt_valid && !cnt_ready) begin
                        overrun <= 1'b1;
                     end
                     if (is_wrap) begin
                        wrap_pulse <= 1'b1;
                        epoch      <= epoch + EPOCH_W'(1);
                     end
`ifdef RIPPLE_CAPTURE_STEP_CHECK_EN
                     if (cand != last + WIDTH'(1)) begin
                        step_err <= 1'b1;
                     end
`endif
                  end else begin
                     stab <= stab + 4'd1;
                  end
               end else if (match_last) begin
                  // Glitch returned to the accepted value: drop it silently
                  state <= StTrack;
               end else begin
                  cand <= sync2;
                  stab <= 4'd1;
               end
            end

            default: state <= StInit;
         endcase
      end
   end

`ifndef RIPPLE_CAPTURE_STEP_CHECK_EN
   assign step_err = 1'b0;
`endif

endmodule
